// File: rtl/div_if.sv
// Execute-stage to divider handshake: operands and request in, {remainder, quotient} and ready out.
interface div_if;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/div.sv
// Multi-cycle 32-bit signed/unsigned restoring divider for DIV/DIVU; result is {remainder, quotient}.
//
// state  | meaning
// FREE   | idle, waiting for start_i
// BYZERO | divisor was zero, result forced to 0
// ON     | one quotient bit per cycle, 32 iterations
// END    | result held until start_i drops
module div (
  input  logic  clk,
  input  logic  rst,
  div_if.slave  bus
);

  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

  state_t      state, state_n;
  logic [4:0]  cnt, cnt_n;
  logic [31:0] d, d_n;
  logic [31:0] q, q_n;
  logic [31:0] r, r_n;
  logic        neg_q, neg_q_n;
  logic        neg_r, neg_r_n;
  logic [63:0] result, result_n;
  logic        ready, ready_n;

  logic [32:0] t;
  logic        ge;
  logic [31:0] r_step;
  logic [31:0] q_step;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= FREE;
      cnt    <= '0;
      d      <= '0;
      q      <= '0;
      r      <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      result <= '0;
      ready  <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      d      <= d_n;
      q      <= q_n;
      r      <= r_n;
      neg_q  <= neg_q_n;
      neg_r  <= neg_r_n;
      result <= result_n;
      ready  <= ready_n;
    end
  end

  // R < D keeps T < 2D, so a 32-bit subtract is exact whenever T >= D
  always_comb begin
    t      = {r, q[31]};
    ge     = (t >= {1'b0, d});
    r_step = ge ? (t[31:0] - d) : t[31:0];
    q_step = {q[30:0], ge};
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    d_n      = d;
    q_n      = q;
    r_n      = r;
    neg_q_n  = neg_q;
    neg_r_n  = neg_r;
    result_n = result;
    ready_n  = ready;

    case (state)
      FREE: begin
        if (bus.start_i && !bus.annul_i) begin
          neg_q_n = bus.signed_div_i & (bus.opdata1_i[31] ^ bus.opdata2_i[31]);
          neg_r_n = bus.signed_div_i & bus.opdata1_i[31];
          q_n     = (bus.signed_div_i && bus.opdata1_i[31]) ? -bus.opdata1_i : bus.opdata1_i;
          d_n     = (bus.signed_div_i && bus.opdata2_i[31]) ? -bus.opdata2_i : bus.opdata2_i;
          r_n     = '0;
          cnt_n   = '0;
          state_n = (bus.opdata2_i == 32'd0) ? BYZERO : ON;
        end
      end
      BYZERO: begin
        result_n = '0;
        ready_n  = 1'b1;
        state_n  = END;
      end
      ON: begin
        r_n   = r_step;
        q_n   = q_step;
        cnt_n = cnt + 5'd1;
        if (cnt == 5'd31) begin
          result_n = {neg_r ? -r_step : r_step, neg_q ? -q_step : q_step};
          ready_n  = 1'b1;
          state_n  = END;
        end
      end
      END: begin
        if (!bus.start_i) begin
          result_n = '0;
          ready_n  = 1'b0;
          state_n  = FREE;
        end
      end
      default: state_n = FREE;
    endcase

    // a flush wins over any iteration or completion on the same edge
    if (bus.annul_i && state != FREE) begin
      state_n  = FREE;
      cnt_n    = '0;
      r_n      = '0;
      result_n = '0;
      ready_n  = 1'b0;
    end
  end

  assign bus.result_o = result;
  assign bus.ready_o  = ready;

endmodule

// File: tb/tb_div.sv
// Scoreboard bench for div: expected result and latency queued at drive time, popped when ready_o rises.
module tb_div;
  logic clk;
  logic rst;
  div_if bus ();

  div dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_res_q[$];
  int          exp_lat_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [63:0] model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ma, mb, qq, rr;
    if (b == 32'd0) return 64'd0;
    ma = (sgn && a[31]) ? -a : a;
    mb = (sgn && b[31]) ? -b : b;
    qq = ma / mb;
    rr = ma % mb;
    if (sgn && (a[31] ^ b[31])) qq = -qq;
    if (sgn && a[31]) rr = -rr;
    return {rr, qq};
  endfunction

  task automatic do_div(input string tag, input bit sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp_v, input bit disturb);
    int lat;
    bit got;
    logic [63:0] e_res;
    int e_lat;
    @(negedge clk);
    bus.signed_div_i = sgn;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.start_i      = 1'b1;
    exp_res_q.push_back(exp_v);
    exp_lat_q.push_back((b == 32'd0) ? 2 : 33);
    lat = 0;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk);
      lat++;
      #1;
      if (bus.ready_o) got = 1'b1;
      else begin
        if (lat == 1) check({tag, "_busy_res"}, bus.result_o, 64'd0);
        if (disturb) begin
          bus.opdata1_i    = $urandom;
          bus.opdata2_i    = $urandom;
          bus.signed_div_i = ~bus.signed_div_i;
        end
      end
    end
    e_res = exp_res_q.pop_front();
    e_lat = exp_lat_q.pop_front();
    if (!got) begin
      check({tag, "_timeout"}, 64'd0, 64'd1);
    end else begin
      check({tag, "_lat"}, 64'(lat), 64'(e_lat));
      check({tag, "_res"}, bus.result_o, e_res);
    end
    @(posedge clk); #1;
    check({tag, "_hold"}, {bus.result_o[62:0], bus.ready_o}, {e_res[62:0], got});
    @(negedge clk);
    bus.start_i = 1'b0;
    @(posedge clk); #1;
    check({tag, "_drop"}, {bus.result_o[62:0], bus.ready_o}, 64'd0);
  endtask

  task automatic start_and_wait(input logic [31:0] a, input logic [31:0] b, input int edges);
    @(negedge clk);
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.start_i      = 1'b1;
    repeat (edges) @(posedge clk);
  endtask

  initial begin
    bit rose;
    logic [31:0] ra, rb;
    bit rs;
    rst = 1'b1;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = '0;
    bus.opdata2_i    = '0;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out", {bus.result_o[62:0], bus.ready_o}, 64'd0);
    check("reset_state", 64'(dut.state), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    do_div("u100_7", 1'b0, 32'd100, 32'd7, {32'h00000002, 32'h0000000E}, 1'b0);
    do_div("s_m7_2", 1'b1, 32'hFFFFFFF9, 32'h00000002, {32'hFFFFFFFF, 32'hFFFFFFFD}, 1'b0);
    do_div("s_7_m2", 1'b1, 32'h00000007, 32'hFFFFFFFE, {32'h00000001, 32'hFFFFFFFD}, 1'b0);
    do_div("dz_u", 1'b0, 32'h12345678, 32'd0, 64'd0, 1'b0);
    do_div("dz_s", 1'b1, 32'h12345678, 32'd0, 64'd0, 1'b0);
    do_div("s_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h00000000, 32'h80000000}, 1'b0);
    do_div("u_max", 1'b0, 32'hFFFFFFFF, 32'h00000001, {32'h00000000, 32'hFFFFFFFF}, 1'b0);

    // annul after the 10th iteration
    start_and_wait(32'd1000, 32'd3, 11);
    @(negedge clk);
    bus.annul_i = 1'b1;
    bus.start_i = 1'b0;
    @(posedge clk); #1;
    check("annul_state", 64'(dut.state), 64'd0);
    bus.annul_i = 1'b0;
    rose = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.ready_o) rose = 1'b1;
    end
    check("annul_no_ready", 64'(rose), 64'd0);
    do_div("after_annul", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 1'b0);

    do_div("disturb_u", 1'b0, 32'd123456789, 32'd1000, model(1'b0, 32'd123456789, 32'd1000), 1'b1);
    do_div("disturb_s", 1'b1, 32'hFFFF0000, 32'd77, model(1'b1, 32'hFFFF0000, 32'd77), 1'b1);

    // reset in the middle of an ON phase
    start_and_wait(32'd5000, 32'd7, 13);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_out", {bus.result_o[62:0], bus.ready_o}, 64'd0);
    check("rst_mid_state", 64'(dut.state), 64'd0);
    check("rst_mid_cnt", 64'(dut.cnt), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.start_i = 1'b0;
    @(posedge clk);

    for (int k = 0; k < 6; k++) begin
      ra = $urandom;
      rb = (k == 0) ? 32'd1 : ($urandom >> $urandom_range(0, 28));
      rs = k[0];
      do_div("rand", rs, ra, rb, model(rs, ra, rb), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/div.md
# div

Multi-cycle 32-bit signed/unsigned divider for the DIV/DIVU instructions. The execute stage drives it and holds a stall request while a divide is in flight, then writes the 64-bit result into HI/LO. The block implements a four-state sequencer around a one-bit-per-cycle restoring division datapath. Result layout: remainder in the upper word (HI), quotient in the lower word (LO).

## Interface
- No parameters; datapath width fixed at 32 bits.
- clk  input  1  rising-edge clock.
- rst  input  1  reset, synchronous, active-high.
- signed_div_i  input  1  1 = signed divide (DIV), 0 = unsigned (DIVU); sampled with start.
- opdata1_i  input  32  dividend; sampled with start.
- opdata2_i  input  32  divisor; sampled with start.
- start_i  input  1  request; level-held by execute stage until it consumes the result.
- annul_i  input  1  cancel in-flight divide (branch/flush).
- result_o  output  64  {remainder, quotient}; valid only while ready_o = 1, else 0.
- ready_o  output  1  result valid.

## Operation
- States: FREE, BYZERO, ON, END. Reset → FREE, ready_o = 0, result_o = 0, counter = 0.
- FREE:
  - With start_i = 1 and annul_i = 0, latch operands and sign mode.
    - Divisor == 0 → BYZERO.
    - Otherwise → ON, counter = 0.
  - Operand conversion at latch, signed mode:
    - D = |opdata2_i|; Q = |opdata1_i| (two's-complement negate when bit 31 is set).
    - Record neg_q = op1[31] ^ op2[31] and neg_r = op1[31].
  - Operand conversion at latch, unsigned mode: D = opdata2_i, Q = opdata1_i, neg_q = neg_r = 0.
  - R = 0.
  - start_i with annul_i = 1 is ignored (stay FREE).
- BYZERO: one cycle, then → END with result 0.
- ON: one iteration per cycle, 32 iterations (counter 0..31).
  - T = {R, Q[31]}, 33 bits.
  - If T ≥ {1'b0, D}: R = (T − D)[31:0], qbit = 1. Else: R = T[31:0], qbit = 0.
  - Q = {Q[30:0], qbit}; counter += 1.
  - Invariant R < D, so T < 2D fits 33 bits.
  - On the iteration with counter == 31:
    - Apply sign fix: quotient = neg_q ? −Q : Q; remainder = neg_r ? −R : R (32-bit wrap).
    - Register result_o = {remainder, quotient}, set ready_o = 1, → END.
- END:
  - Hold result_o and ready_o while start_i = 1.
  - When start_i = 0 → FREE, ready_o = 0, result_o = 0.
- annul_i = 1 in BYZERO, ON or END → FREE next edge, ready_o = 0, result_o = 0, partial state discarded. It overrides both iteration and completion on the same edge.
- Operand input changes after latch have no effect.
- Overflow case 0x80000000 / 0xFFFFFFFF (signed) is defined, not trapped: quotient 0x80000000, remainder 0.
- Execute stage stall rule: stall_req = start_i & ~ready_o. This block exports only ready_o.

## Timing
- Start sampled at edge k (FREE → ON); iterations at edges k+1 … k+32; ready_o = 1 from edge k+32.
- Result visible 33 cycles after the cycle start_i is first seen high in FREE.
- Divide by zero: edge k → BYZERO, edge k+1 → END; ready_o visible 2 cycles after start.
- A new divide cannot begin until the FSM has returned to FREE. start_i must drop for at least one cycle between back-to-back divides (one idle cycle minimum).
- rst has priority over annul_i, which has priority over all transitions. rst mid-ON aborts with no residual state.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Unsigned 100 / 7, start held:
  - ready_o rises exactly 33 cycles after start.
  - result_o = {0x00000002, 0x0000000E}.
  - Drop start → ready_o = 0 and result_o = 0 next cycle.
- Signed −7 / 2 (0xFFFFFFF9, 0x00000002): result_o = {0xFFFFFFFF, 0xFFFFFFFD}. Repeat with 7 / −2 → {0x00000001, 0xFFFFFFFD}.
- Divide by zero (0x12345678 / 0), both modes: ready_o after 2 cycles, result_o = 0.
- Signed 0x80000000 / 0xFFFFFFFF → {0x00000000, 0x80000000}. Unsigned 0xFFFFFFFF / 0x00000001 → {0x00000000, 0xFFFFFFFF}.
- annul_i pulsed at iteration 10:
  - FSM returns to FREE and ready_o never rises.
  - A following 9 / 3 divide gives {0, 3} with full 33-cycle latency.
- Operand disturbance: change opdata1_i/opdata2_i every cycle during ON → result unaffected. Assert rst mid-ON → all outputs 0 next cycle, FSM in FREE.
